// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table scanner.
// Holds the FSM state enum, settle width and row-count helper.
package truth_table_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam int SETTLE_W = 4;

  function automatic int rows_of(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Load/clear down-counter used to hold each stimulus row.
// tc_o is high whenever the count has reached zero.
module settle_timer
  import truth_table_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         clear_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all input rows of a gate pair, samples both outputs
// into truth-table vectors and reports difference and match.
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  output logic [N_IN-1:0]            stim_o,
  input  logic                       res_a_i,
  input  logic                       res_b_i,
  output logic [rows_of(N_IN)-1:0]   tt_a_o,
  output logic [rows_of(N_IN)-1:0]   tt_b_o,
  output logic [rows_of(N_IN)-1:0]   diff_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       match_o
);

  localparam int ROWS = rows_of(N_IN);
  localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};
  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

  state_e          state_q;
  logic [N_IN-1:0] stim_q;
  logic [ROWS-1:0] tt_a_q;
  logic [ROWS-1:0] tt_b_q;
  logic [ROWS-1:0] tt_a_d;
  logic [ROWS-1:0] tt_b_d;
  logic            busy_q;
  logic            done_q;
  logic            match_q;

  logic            is_last;
  logic            accept;
  logic            tmr_load;
  logic            tmr_en;
  logic            tmr_clr;
  logic            tmr_tc;

  assign is_last  = (stim_q == LAST);
  assign accept   = (state_q == S_IDLE) && start_i;
  assign tmr_load = accept || ((state_q == S_SAMPLE) && !is_last);
  assign tmr_en   = (state_q == S_DRIVE);
  assign tmr_clr  = (state_q == S_DONE);

  settle_timer #(
    .W (SETTLE_W)
  ) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .en_i       (tmr_en),
    .clear_i    (tmr_clr),
    .tc_o       (tmr_tc)
  );

  // Next vectors include the row being sampled, so match sees it too.
  always_comb begin
    tt_a_d         = tt_a_q;
    tt_b_d         = tt_b_q;
    tt_a_d[stim_q] = res_a_i;
    tt_b_d[stim_q] = res_b_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      tt_a_q  <= '0;
      tt_b_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_DRIVE;
            stim_q  <= '0;
            tt_a_q  <= '0;
            tt_b_q  <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (tmr_tc) begin
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          tt_a_q <= tt_a_d;
          tt_b_q <= tt_b_d;
          if (is_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            match_q <= (tt_a_d == tt_b_d);
          end else begin
            state_q <= S_DRIVE;
            stim_q  <= stim_q + N_IN'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stim_o  = stim_q;
  assign tt_a_o  = tt_a_q;
  assign tt_b_o  = tt_b_q;
  assign diff_o  = tt_a_q ^ tt_b_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign match_o = match_q;

endmodule
